// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg -- shared definitions for the ALU arbiter slice.
//   * data/opcode widths
//   * FSM state encoding (IDLE/EXEC)
//   * ALUOp codes understood by the shared alu instance
//   * LOCK_EN: 1 when the build defines ALU_ARB_LOCK_EN (requester lock
//     ports present), 0 otherwise (pure round-robin)
package alu_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

`ifdef ALU_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // ALUOp codes
  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 5'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'd5;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'd6;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'd7;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'd8;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'd9;

endpackage

// File: rtl/alu_arb_if.sv
// alu_arb_if -- bundle of the two requester ports, their response ports
// and the link to the shared alu.
//   slave  : arbiter side (alu_arb)
//   master : requesters + alu side (parent / testbench)
// Optional: with ALU_ARB_LOCK_EN defined, req0_lock/req1_lock are added.
//
// Handshake: a request transfers on a rising clk edge where reqN_valid and
// reqN_ready are both high. A requester holds valid, operands (and lock)
// stable until that edge. Responses have no back-pressure: rspN_c/rspN_zero
// are sampled during the single cycle rspN_valid is high and then hold.
interface alu_arb_if;
  import alu_arb_pkg::*;

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]   req0_op, req1_op;
`ifdef ALU_ARB_LOCK_EN
  logic              req0_lock, req1_lock;
`endif

  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_c, rsp1_c;
  logic              rsp0_zero, rsp1_zero;

  logic [DATA_W-1:0] alu_a, alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_c;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  req0_op, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_c, rsp1_c, rsp0_zero, rsp1_zero,
    output alu_a, alu_b, alu_op,
    input  alu_c, alu_zero
`ifdef ALU_ARB_LOCK_EN
    , input req0_lock, req1_lock
`endif
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output req0_op, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_c, rsp1_c, rsp0_zero, rsp1_zero,
    input  alu_a, alu_b, alu_op,
    output alu_c, alu_zero
`ifdef ALU_ARB_LOCK_EN
    , output req0_lock, req1_lock
`endif
  );

endinterface

// File: rtl/alu_arb_rr_arb2.sv
// rr_arb2 -- two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   valid[1:0] : requesters asking for a grant
//   update     : the current grant was taken; remember it as last winner
//   lock_hold  : only the last winner is eligible
//   grant[1:0] : one-hot winner, or zero when nobody is eligible
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  input  logic       lock_hold,
  output logic [1:0] grant
);

  // Index of the most recent winner. Reset to 1 so req0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= grant[1];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (lock_hold) begin
      if (last_q) grant[1] = valid[1];
      else        grant[0] = valid[0];
    end else if (valid == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb -- shares one external alu between two requesters.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : alu_arb_if.slave (requests, responses, alu link)
//   dbg_state : current FSM state
// One operation takes two cycles: accept in IDLE, the alu evaluates the
// operand registers in EXEC, the result is captured at the end of EXEC and
// the owner's rspN_valid pulses in the following cycle (which may itself
// be an accept cycle).
// Optional: ALU_ARB_LOCK_EN adds requester locks; an accepted lock=1
// request keeps that requester as the only eligible winner until it gets
// an accepted lock=0 request.
module alu_arb
  import alu_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  alu_arb_if.slave   bus,
  output state_t     dbg_state
);

  state_t            state_q, state_d;
  logic [1:0]        valid, grant, ready;
  logic              accept;
  logic              owner_q;
  logic              lock_q;
  logic              lock_hold;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp0_c_q, rsp1_c_q;
  logic              rsp0_zero_q, rsp1_zero_q;

  assign valid     = {bus.req1_valid, bus.req0_valid};
  assign lock_hold = LOCK_EN && lock_q;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .update    (accept),
    .lock_hold (lock_hold),
    .grant     (grant)
  );

  always_comb begin
    state_d = state_q;
    ready   = 2'b00;
    case (state_q)
      IDLE: begin
        if (!rst) ready = grant;
        if (ready != 2'b00) state_d = EXEC;
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant is a subset of valid, so any ready bit is a completed handshake
  assign accept = (ready != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lock_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 2'b00;
      rsp0_c_q    <= '0;
      rsp1_c_q    <= '0;
      rsp0_zero_q <= 1'b0;
      rsp1_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 2'b00;
      if (accept) begin
        owner_q <= ready[1];
        if (ready[1]) begin
          a_q  <= bus.req1_a;
          b_q  <= bus.req1_b;
          op_q <= bus.req1_op;
        end else begin
          a_q  <= bus.req0_a;
          b_q  <= bus.req0_b;
          op_q <= bus.req0_op;
        end
`ifdef ALU_ARB_LOCK_EN
        lock_q <= ready[1] ? bus.req1_lock : bus.req0_lock;
`endif
      end
      if (state_q == EXEC) begin
        rsp_valid_q[owner_q] <= 1'b1;
        if (owner_q) begin
          rsp1_c_q    <= bus.alu_c;
          rsp1_zero_q <= bus.alu_zero;
        end else begin
          rsp0_c_q    <= bus.alu_c;
          rsp0_zero_q <= bus.alu_zero;
        end
      end
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_c     = rsp0_c_q;
  assign bus.rsp1_c     = rsp1_c_q;
  assign bus.rsp0_zero  = rsp0_zero_q;
  assign bus.rsp1_zero  = rsp1_zero_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb -- bench for alu_arb with a behavioural alu on the parent side,
// queue-fed requester drivers, a transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_alu_arb;
  import alu_arb_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        lock;
  } op_t;

  typedef struct {
    int          cyc;
    int          n;
    logic [31:0] c;
    logic        zero;
  } ev_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     cyc = 0;
  bit     chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arb_if bus ();

  alu_arb dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- behavioural alu ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      default:  return 32'd0;
    endcase
  endfunction

  assign bus.alu_c    = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero = (bus.alu_c == 32'd0);

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- requester drivers ----------------
  op_t q0[$];
  op_t q1[$];

  initial begin
    op_t t;
    logic acc0, acc1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
`ifdef ALU_ARB_LOCK_EN
    bus.req0_lock = 1'b0; bus.req1_lock = 1'b0;
`endif
    forever begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!bus.req0_valid || acc0) begin
        if (q0.size() > 0) begin
          t = q0.pop_front();
          bus.req0_valid = 1'b1; bus.req0_a = t.a; bus.req0_b = t.b; bus.req0_op = t.op;
`ifdef ALU_ARB_LOCK_EN
          bus.req0_lock = t.lock;
`endif
        end else begin
          bus.req0_valid = 1'b0;
        end
      end
      if (!bus.req1_valid || acc1) begin
        if (q1.size() > 0) begin
          t = q1.pop_front();
          bus.req1_valid = 1'b1; bus.req1_a = t.a; bus.req1_b = t.b; bus.req1_op = t.op;
`ifdef ALU_ARB_LOCK_EN
          bus.req1_lock = t.lock;
`endif
        end else begin
          bus.req1_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- event logs for directed checks ----------------
  ev_t acc_log[$];
  ev_t pls_log[$];

  always @(negedge clk) begin
    ev_t e;
    e.cyc = cyc; e.c = '0; e.zero = 1'b0;
    if (bus.req0_valid && bus.req0_ready) begin e.n = 0; acc_log.push_back(e); end
    if (bus.req1_valid && bus.req1_ready) begin e.n = 1; acc_log.push_back(e); end
    if (bus.rsp0_valid) begin e.n = 0; e.c = bus.rsp0_c; e.zero = bus.rsp0_zero; pls_log.push_back(e); end
    if (bus.rsp1_valid) begin e.n = 1; e.c = bus.rsp1_c; e.zero = bus.rsp1_zero; pls_log.push_back(e); end
  end

  // ---------------- reference model ----------------
  // Operation-level view: at most one op in flight; the op in flight
  // produces its owner's result pulse one cycle after it occupies the alu.
  bit          m_exec  = 1'b0;
  int          m_owner = 0;
  int          m_last  = 1;
  bit          m_lock  = 1'b0;
  logic [31:0] m_res   = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [4:0]  m_op = '0;
  logic [1:0]  m_v = 2'b00;
  logic [31:0] m_c[2] = '{32'd0, 32'd0};
  logic        m_z[2] = '{1'b0, 1'b0};

  // Who wins this cycle: 0, 1, or 2 for nobody.
  function automatic int pick();
    bit v0, v1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (rst || m_exec) return 2;
    if (m_lock) begin
      if (m_last == 0) return v0 ? 0 : 2;
      return v1 ? 1 : 2;
    end
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return 2;
  endfunction

  always @(negedge clk) begin
    int   w;
    logic lk0, lk1;
    w = pick();
`ifdef ALU_ARB_LOCK_EN
    lk0 = bus.req0_lock; lk1 = bus.req1_lock;
`else
    lk0 = 1'b0; lk1 = 1'b0;
`endif
    if (chk_en) begin
      check("req0_ready", 32'(bus.req0_ready), 32'(w == 0));
      check("req1_ready", 32'(bus.req1_ready), 32'(w == 1));
      check("state",      32'(dbg_state),      32'(m_exec));
      check("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_v[0]));
      check("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_v[1]));
      check("rsp0_c",     bus.rsp0_c,          m_c[0]);
      check("rsp1_c",     bus.rsp1_c,          m_c[1]);
      check("rsp0_zero",  32'(bus.rsp0_zero),  32'(m_z[0]));
      check("rsp1_zero",  32'(bus.rsp1_zero),  32'(m_z[1]));
      check("alu_a",      bus.alu_a,           m_a);
      check("alu_b",      bus.alu_b,           m_b);
      check("alu_op",     32'(bus.alu_op),     32'(m_op));
    end
    // advance the model across the coming rising edge
    if (rst) begin
      m_exec = 1'b0; m_last = 1; m_lock = 1'b0; m_v = 2'b00;
      m_c[0] = '0; m_c[1] = '0; m_z[0] = 1'b0; m_z[1] = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
    end else begin
      m_v = 2'b00;
      if (m_exec) begin
        m_v[m_owner] = 1'b1;
        m_c[m_owner] = m_res;
        m_z[m_owner] = (m_res == 32'd0);
      end
      m_exec = 1'b0;
      if (w == 0) begin
        m_exec = 1'b1; m_owner = 0; m_last = 0; m_lock = lk0;
        m_a = bus.req0_a; m_b = bus.req0_b; m_op = bus.req0_op;
        m_res = alu_f(m_a, m_b, m_op);
      end else if (w == 1) begin
        m_exec = 1'b1; m_owner = 1; m_last = 1; m_lock = lk1;
        m_a = bus.req1_a; m_b = bus.req1_b; m_op = bus.req1_op;
        m_res = alu_f(m_a, m_b, m_op);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] op, input logic lock);
    op_t t;
    t.a = a; t.b = b; t.op = op; t.lock = lock;
    return t;
  endfunction

  function automatic op_t rand_op();
    op_t t;
    t.a    = $urandom();
    t.b    = ($urandom_range(0, 3) == 0) ? t.a : $urandom();
    t.op   = 5'($urandom_range(0, 9));
    t.lock = LOCK_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
    return t;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int guard;
    @(posedge clk);
    #1 chk_en = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);

    // single req0 add 5+3
    acc_log.delete(); pls_log.delete();
    q0.push_back(mk(32'd5, 32'd3, ALU_ADD, 1'b0));
    wait_cycles(8);
    check("add_pulses", 32'(pls_log.size()), 32'd1);
    if (pls_log.size() >= 1 && acc_log.size() >= 1) begin
      check("add_owner",   32'(pls_log[0].n), 32'd0);
      check("add_c",       pls_log[0].c, 32'd8);
      check("add_zero",    32'(pls_log[0].zero), 32'd0);
      check("add_latency", 32'(pls_log[0].cyc - acc_log[0].cyc), 32'd2);
    end

    // both valid straight out of reset: req0 first
    do_reset();
    acc_log.delete(); pls_log.delete();
    q0.push_back(mk(32'd7, 32'd7, ALU_SUB, 1'b0));
    q1.push_back(mk(32'hF0, 32'h0F, ALU_XOR, 1'b0));
    wait_cycles(10);
    check("both_pulses", 32'(pls_log.size()), 32'd2);
    if (pls_log.size() >= 2) begin
      check("both_first",  32'(pls_log[0].n), 32'd0);
      check("both_c0",     pls_log[0].c, 32'd0);
      check("both_zero0",  32'(pls_log[0].zero), 32'd1);
      check("both_second", 32'(pls_log[1].n), 32'd1);
      check("both_c1",     pls_log[1].c, 32'hFF);
      check("both_gap",    32'(pls_log[1].cyc - pls_log[0].cyc), 32'd2);
    end

    // 8 ops with both held valid: strict alternation, one grant per 2 cycles
    acc_log.delete(); pls_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(32'(i), 32'd1, ALU_ADD, 1'b0));
      q1.push_back(mk(32'(i), 32'd2, ALU_ADD, 1'b0));
    end
    wait_cycles(24);
    check("alt_count", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8) begin
      check("alt_first", 32'(acc_log[0].n), 32'd0);
      for (int i = 1; i < 8; i++) begin
        check("alt_owner", 32'(acc_log[i].n), 32'(1 - acc_log[i-1].n));
        check("alt_gap",   32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'd2);
      end
    end

    // back-to-back req0 ops: second accept in the first pulse cycle
    acc_log.delete(); pls_log.delete();
    q0.push_back(mk(32'd1, 32'd1, ALU_ADD, 1'b0));
    q0.push_back(mk(32'd2, 32'd2, ALU_ADD, 1'b0));
    wait_cycles(10);
    check("b2b_pulses", 32'(pls_log.size()), 32'd2);
    if (pls_log.size() == 2 && acc_log.size() == 2) begin
      check("b2b_c0",  pls_log[0].c, 32'd2);
      check("b2b_c1",  pls_log[1].c, 32'd4);
      check("b2b_gap", 32'(pls_log[1].cyc - pls_log[0].cyc), 32'd2);
      check("b2b_acc_in_pulse", 32'(acc_log[1].cyc), 32'(pls_log[0].cyc));
    end

    // reset during the EXEC cycle of a req1 op
    acc_log.delete(); pls_log.delete();
    q1.push_back(mk(32'd3, 32'd4, ALU_ADD, 1'b0));
    guard = 0;
    while (acc_log.size() == 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    check("abort_accept_seen", 32'(acc_log.size() > 0), 32'd1);
    #1 rst = 1'b1;               // held across the edge that ends EXEC
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cycles(5);
    cnt = 0;
    foreach (pls_log[i]) if (pls_log[i].n == 1) cnt++;
    check("abort_no_rsp1", 32'(cnt), 32'd0);
    check("abort_idle",    32'(dbg_state), 32'(IDLE));
    acc_log.delete(); pls_log.delete();
    q0.push_back(mk(32'd9, 32'd1, ALU_SUB, 1'b0));
    q1.push_back(mk(32'd9, 32'd9, ALU_AND, 1'b0));
    wait_cycles(10);
    check("abort_next_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) check("abort_next_first", 32'(acc_log[0].n), 32'd0);

`ifdef ALU_ARB_LOCK_EN
    // req0 locks through three ops while req1 waits
    do_reset();
    acc_log.delete(); pls_log.delete();
    q1.push_back(mk(32'd1, 32'd2, ALU_OR, 1'b0));
    q0.push_back(mk(32'd5, 32'd5, ALU_SUB, 1'b1));
    q0.push_back(mk(32'd6, 32'd5, ALU_SLT, 1'b1));
    q0.push_back(mk(32'd7, 32'd5, ALU_ADD, 1'b0));
    wait_cycles(14);
    check("lock_count", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4) begin
      check("lock_g0", 32'(acc_log[0].n), 32'd0);
      check("lock_g1", 32'(acc_log[1].n), 32'd0);
      check("lock_g2", 32'(acc_log[2].n), 32'd0);
      check("lock_g3", 32'(acc_log[3].n), 32'd1);
    end
`endif

    // randomized traffic with occasional resets; the model checks every cycle
    for (int i = 0; i < 500; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
      rst = ($urandom_range(0, 79) == 0);
      wait_cycles(1);
    end
    rst = 1'b0;
    wait_cycles(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
